// File: rtl/renas_mem_ctrl.sv
// renas_mem_ctrl: single-clock main-memory controller for the renas MCU.
// NUM_CH round-robin request channels share one byte-strobed word array with
// a write-back FIFO. A read that hits a pending write-back waits until that
// entry has drained, so reads never see stale data.
module renas_mem_ctrl #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                MEM_WORDS = 16384,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h400,
  parameter int                NUM_CH    = 2,
  parameter int                WB_DEPTH  = 4,
  parameter int                RD_LAT    = 2
) (
  input  logic                       cache_clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_we,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  input  logic [NUM_CH*DATA_W/8-1:0] ch_be,
  output logic [NUM_CH-1:0]          ch_gnt,
  output logic [NUM_CH-1:0]          ch_rvalid,
  output logic [NUM_CH*DATA_W-1:0]   ch_rdata,
  output logic [NUM_CH-1:0]          ch_err,
  input  logic                       wb_req,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  output logic                       wb_ack,
  output logic                       wb_full,
  output logic [$clog2(WB_DEPTH):0]  wb_count
);

  localparam int BE_W   = DATA_W / 8;
  localparam int PTR_W  = $clog2(WB_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MIDX_W = $clog2(MEM_WORDS);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic [ADDR_W-1:0] ch_idx [NUM_CH];
  logic [NUM_CH-1:0] ch_oob;
  logic [ADDR_W-1:0] wb_idx;
  logic              wb_oob;

  logic [ADDR_W-1:0] fifo_idx  [WB_DEPTH];
  logic [DATA_W-1:0] fifo_data [WB_DEPTH];
  logic [WB_DEPTH-1:0] fifo_oob;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, hz_slot;
  logic              fifo_empty;

  logic [CH_W-1:0]   rr_ptr, gnt_ch;
  logic [NUM_CH-1:0] hazard, eligible, gnt;
  logic              gnt_any, drain;
  int                rr_cand;

  logic              sel_we, sel_oob;
  logic [MIDX_W-1:0] sel_idx;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;

  logic [RD_LAT-1:0] pipe_vld, pipe_err;
  logic [CH_W-1:0]   pipe_ch   [RD_LAT];
  logic [DATA_W-1:0] pipe_data [RD_LAT];

  // Decode byte addresses into word indices and range-check them.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_idx[i] = (ch_addr[i*ADDR_W +: ADDR_W] - BASE_ADDR) >> 2;
      ch_oob[i] = (ch_addr[i*ADDR_W +: ADDR_W] < BASE_ADDR) ||
                  (ch_idx[i] >= ADDR_W'(MEM_WORDS));
    end
    wb_idx = (wb_addr - BASE_ADDR) >> 2;
    wb_oob = (wb_addr < BASE_ADDR) || (wb_idx >= ADDR_W'(MEM_WORDS));
  end

  assign wb_full    = (wb_count == CNT_W'(WB_DEPTH));
  assign fifo_empty = (wb_count == '0);
  assign wb_ack     = rst_n & wb_req & ~wb_full;

  // Flag reads whose word is pending in the FIFO or being pushed this cycle.
  always_comb begin
    hazard  = '0;
    hz_slot = rd_ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_req[i] && !ch_we[i]) begin
        for (int k = 0; k < WB_DEPTH; k++) begin
          hz_slot = rd_ptr + PTR_W'(k);
          if ((CNT_W'(k) < wb_count) && (fifo_idx[hz_slot] == ch_idx[i]))
            hazard[i] = 1'b1;
        end
        if (wb_ack && (wb_idx == ch_idx[i]))
          hazard[i] = 1'b1;
      end
    end
  end

  // Arbitrate the single array port: forced drains, then round-robin, then idle drain.
  always_comb begin
    gnt      = '0;
    gnt_ch   = '0;
    gnt_any  = 1'b0;
    drain    = 1'b0;
    rr_cand  = 0;
    eligible = ch_req & ~hazard;
    if (rst_n) begin
      if (wb_full || (|hazard && !fifo_empty)) begin
        drain = 1'b1;
      end else begin
        for (int k = 0; k < NUM_CH; k++) begin
          rr_cand = (int'(rr_ptr) + k) % NUM_CH;
          if (!gnt_any && eligible[rr_cand]) begin
            gnt_any = 1'b1;
            gnt_ch  = CH_W'(rr_cand);
          end
        end
        if (gnt_any)
          gnt[gnt_ch] = 1'b1;
        else if (!fifo_empty)
          drain = 1'b1;
      end
    end
    sel_we    = ch_we[gnt_ch];
    sel_oob   = ch_oob[gnt_ch];
    sel_idx   = ch_idx[gnt_ch][MIDX_W-1:0];
    sel_wdata = ch_wdata[int'(gnt_ch)*DATA_W +: DATA_W];
    sel_be    = ch_be[int'(gnt_ch)*BE_W +: BE_W];
  end

  assign ch_gnt = gnt;

  // FIFO pointers, occupancy and round-robin pointer.
  always_ff @(posedge cache_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      wb_count <= '0;
      rr_ptr   <= '0;
    end else begin
      if (wb_ack) wr_ptr <= wr_ptr + 1'b1;
      if (drain)  rd_ptr <= rd_ptr + 1'b1;
      case ({wb_ack, drain})
        2'b10:   wb_count <= wb_count + 1'b1;
        2'b01:   wb_count <= wb_count - 1'b1;
        default: wb_count <= wb_count;
      endcase
      if (gnt_any)
        rr_ptr <= (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
    end
  end

  // FIFO entry storage; contents need no reset because occupancy gates them.
  always_ff @(posedge cache_clk) begin
    if (wb_ack) begin
      fifo_idx[wr_ptr]  <= wb_idx;
      fifo_data[wr_ptr] <= wb_data;
      fifo_oob[wr_ptr]  <= wb_oob;
    end
  end

  // Array writes: full-word FIFO drain or byte-strobed channel write; out-of-range dropped.
  always_ff @(posedge cache_clk) begin
    if (drain) begin
      if (!fifo_oob[rd_ptr])
        mem[fifo_idx[rd_ptr][MIDX_W-1:0]] <= fifo_data[rd_ptr];
    end else if (gnt_any && sel_we && !sel_oob) begin
      for (int b = 0; b < BE_W; b++)
        if (sel_be[b])
          mem[sel_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
    end
  end

  // Read pipeline: array sampled at the grant edge, then delayed to RD_LAT.
  always_ff @(posedge cache_clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      pipe_err <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        pipe_ch[s]   <= '0;
        pipe_data[s] <= '0;
      end
    end else begin
      pipe_vld[0]  <= gnt_any & ~sel_we;
      pipe_err[0]  <= sel_oob;
      pipe_ch[0]   <= gnt_ch;
      pipe_data[0] <= sel_oob ? '0 : mem[sel_idx];
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_vld[s]  <= pipe_vld[s-1];
        pipe_err[s]  <= pipe_err[s-1];
        pipe_ch[s]   <= pipe_ch[s-1];
        pipe_data[s] <= pipe_data[s-1];
      end
    end
  end

  // Steer the last pipeline stage onto the owning channel's outputs.
  always_comb begin
    ch_rvalid = '0;
    ch_err    = '0;
    ch_rdata  = '0;
    if (pipe_vld[RD_LAT-1]) begin
      ch_rvalid[pipe_ch[RD_LAT-1]] = 1'b1;
      ch_err[pipe_ch[RD_LAT-1]]    = pipe_err[RD_LAT-1];
      ch_rdata[int'(pipe_ch[RD_LAT-1])*DATA_W +: DATA_W] = pipe_data[RD_LAT-1];
    end
  end

endmodule

// File: tb/tb_renas_mem_ctrl.sv
// tb_renas_mem_ctrl: scoreboard bench for renas_mem_ctrl. Expected read
// responses are queued when a grant is seen; a monitor pops them on rvalid.
module tb_renas_mem_ctrl;
  localparam int NCH = 2;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam logic [31:0] FILL [4] = '{32'h0F0F0001, 32'h2E2E0002, 32'h3D3D0003, 32'h4C4C0004};

  logic              cache_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    ch_req = '0, ch_we = '0;
  logic [NCH*AW-1:0] ch_addr = '0;
  logic [NCH*DW-1:0] ch_wdata = '0;
  logic [NCH*4-1:0]  ch_be = '0;
  logic [NCH-1:0]    ch_gnt, ch_rvalid, ch_err;
  logic [NCH*DW-1:0] ch_rdata;
  logic              wb_req = 1'b0;
  logic [AW-1:0]     wb_addr = '0;
  logic [DW-1:0]     wb_data = '0;
  logic              wb_ack, wb_full;
  logic [2:0]        wb_count;

  typedef struct {int ch; logic [31:0] data; logic err; int cyc;} exp_t;
  exp_t sb[$];
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   w;

  renas_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MEM_WORDS(16384), .BASE_ADDR(32'h400),
                   .NUM_CH(NCH), .WB_DEPTH(4), .RD_LAT(2)) dut (
    .cache_clk(cache_clk), .rst_n(rst_n),
    .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_be(ch_be),
    .ch_gnt(ch_gnt), .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata), .ch_err(ch_err),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_ack(wb_ack), .wb_full(wb_full), .wb_count(wb_count)
  );

  always #5 cache_clk = ~cache_clk;

  always @(posedge cache_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic req, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    ch_req[ch]             = req;
    ch_we[ch]              = we;
    ch_addr[ch*AW +: AW]   = addr;
    ch_wdata[ch*DW +: DW]  = wdata;
    ch_be[ch*4 +: 4]       = be;
  endtask

  task automatic pushExp(input int ch, input logic [31:0] data, input logic err);
    exp_t e;
    e.ch = ch; e.data = data; e.err = err; e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at a negedge with the request dropped.
  task automatic doAccess(input int ch, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be, input logic err,
                          output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    applyStimulus(ch, 1'b1, we, addr, data, be);
    while (!got && waited < 20) begin
      #1;
      if (ch_gnt[ch]) begin
        got = 1'b1;
        checkOutput("gnt_onehot", 64'(ch_gnt), 64'(1 << ch));
        if (!we) pushExp(ch, data, err);
      end
      @(negedge cache_clk);
      if (!got) waited++;
    end
    applyStimulus(ch, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("access_granted", 64'(got), 64'd1);
  endtask

  // Monitor: every rvalid pulse must match the oldest queued expectation.
  always @(negedge cache_clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (ch_rvalid[i]) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rvalid", 64'(ch_rvalid), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("rv_channel", 64'(i), 64'(e.ch));
          checkOutput("rv_data", 64'(ch_rdata[i*DW +: DW]), 64'(e.data));
          checkOutput("rv_err", 64'(ch_err[i]), 64'(e.err));
          checkOutput("rv_latency", 64'(cyc - e.cyc), 64'd2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not finish, expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset with requests asserted: nothing may be granted or acknowledged.
    applyStimulus(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h404, 32'h0, 4'h0);
    wb_req = 1'b1;
    repeat (2) @(negedge cache_clk);
    #1;
    checkOutput("rst_gnt", 64'(ch_gnt), 64'd0);
    checkOutput("rst_rvalid", 64'(ch_rvalid), 64'd0);
    checkOutput("rst_err", 64'(ch_err), 64'd0);
    checkOutput("rst_rdata", ch_rdata, 64'd0);
    checkOutput("rst_wb_full", 64'(wb_full), 64'd0);
    checkOutput("rst_wb_count", 64'(wb_count), 64'd0);
    checkOutput("rst_wb_ack", 64'(wb_ack), 64'd0);
    @(negedge cache_clk);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    wb_req = 1'b0;
    rst_n  = 1'b1;
    @(negedge cache_clk);

    // Preload and first read; rr ends pointing at ch0 after ch1's read.
    doAccess(0, 1'b1, 32'h400, 32'hDEADBEEF, 4'hF, 1'b0, w);
    checkOutput("wr0_immediate", 64'(w), 64'd0);
    doAccess(1, 1'b1, 32'h404, 32'hAAAAAAAA, 4'hF, 1'b0, w);
    doAccess(0, 1'b0, 32'h400, 32'hDEADBEEF, 4'h0, 1'b0, w);
    checkOutput("rd0_immediate", 64'(w), 64'd0);
    doAccess(1, 1'b0, 32'h404, 32'hAAAAAAAA, 4'h0, 1'b0, w);

    // Both channels hold reads: grants alternate 0,1,0,1.
    applyStimulus(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h404, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("rr_alternate", 64'(ch_gnt), (k % 2 == 0) ? 64'd1 : 64'd2);
      if (k % 2 == 0) pushExp(0, 32'hDEADBEEF, 1'b0);
      else            pushExp(1, 32'hAAAAAAAA, 1'b0);
      @(negedge cache_clk);
    end
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Byte-strobed write merges into the existing word.
    doAccess(0, 1'b1, 32'h404, 32'h11223344, 4'b0101, 1'b0, w);
    doAccess(0, 1'b0, 32'h404, 32'hAA22AA44, 4'h0, 1'b0, w);

    // Read hitting a write-back pushed in the same cycle waits for the drain.
    wb_req = 1'b1; wb_addr = 32'h800; wb_data = 32'hCAFEF00D;
    applyStimulus(1, 1'b1, 1'b0, 32'h800, 32'h0, 4'h0);
    #1;
    checkOutput("haz_push_ack", 64'(wb_ack), 64'd1);
    checkOutput("haz_blocked_c0", 64'(ch_gnt), 64'd0);
    @(negedge cache_clk);
    wb_req = 1'b0;
    #1;
    checkOutput("haz_blocked_c1", 64'(ch_gnt), 64'd0);
    checkOutput("haz_count", 64'(wb_count), 64'd1);
    @(negedge cache_clk);
    #1;
    checkOutput("haz_granted", 64'(ch_gnt), 64'd2);
    pushExp(1, 32'hCAFEF00D, 1'b0);
    @(negedge cache_clk);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Fill the FIFO while both channels stay busy, then a forced drain.
    applyStimulus(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h404, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      wb_req = 1'b1; wb_addr = 32'hC00 + 32'(4 * k); wb_data = FILL[k];
      #1;
      checkOutput("fill_ack", 64'(wb_ack), 64'd1);
      checkOutput("fill_gnt", 64'(ch_gnt), (k % 2 == 0) ? 64'd1 : 64'd2);
      if (k % 2 == 0) pushExp(0, 32'hDEADBEEF, 1'b0);
      else            pushExp(1, 32'hAA22AA44, 1'b0);
      @(negedge cache_clk);
    end
    wb_addr = 32'hC10; wb_data = 32'hBAD0BAD0;
    #1;
    checkOutput("full_flag", 64'(wb_full), 64'd1);
    checkOutput("full_ack", 64'(wb_ack), 64'd0);
    checkOutput("full_gnt", 64'(ch_gnt), 64'd0);
    checkOutput("full_count", 64'(wb_count), 64'd4);
    @(negedge cache_clk);
    wb_req = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    checkOutput("after_drain_count", 64'(wb_count), 64'd3);
    w = 0;
    while (wb_count != 0 && w < 10) begin
      @(negedge cache_clk);
      w++;
    end
    checkOutput("fifo_drained", 64'(wb_count), 64'd0);
    @(negedge cache_clk);
    for (int k = 0; k < 4; k++)
      doAccess(0, 1'b0, 32'hC00 + 32'(4 * k), FILL[k], 4'h0, 1'b0, w);

    // Two pending entries to one word: last pushed wins, read waits one drain.
    wb_req = 1'b1; wb_addr = 32'hD00; wb_data = 32'h11111111;
    @(negedge cache_clk);
    wb_data = 32'h22222222;
    @(negedge cache_clk);
    wb_req = 1'b0;
    doAccess(0, 1'b0, 32'hD00, 32'h22222222, 4'h0, 1'b0, w);
    checkOutput("dup_wait", 64'(w), 64'd1);

    // Range boundaries: below base, first word past end, last valid word.
    doAccess(0, 1'b0, 32'h300, 32'h0, 4'h0, 1'b1, w);
    doAccess(1, 1'b0, 32'h10400, 32'h0, 4'h0, 1'b1, w);
    doAccess(0, 1'b1, 32'h103FC, 32'h5A5A5A5A, 4'hF, 1'b0, w);
    doAccess(0, 1'b0, 32'h103FC, 32'h5A5A5A5A, 4'h0, 1'b0, w);
    doAccess(1, 1'b1, 32'h10400, 32'hFFFFFFFF, 4'hF, 1'b0, w);
    doAccess(0, 1'b0, 32'h400, 32'hDEADBEEF, 4'h0, 1'b0, w);

    // Reset one cycle after a read grant: no rvalid, FIFO emptied, array kept.
    applyStimulus(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
    wb_req = 1'b1; wb_addr = 32'hE00; wb_data = 32'h33333333;
    #1;
    checkOutput("mid_gnt", 64'(ch_gnt), 64'd1);
    checkOutput("mid_ack", 64'(wb_ack), 64'd1);
    @(negedge cache_clk);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    checkOutput("mid_count_pre", 64'(wb_count), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_count_rst", 64'(wb_count), 64'd0);
    checkOutput("mid_ack_rst", 64'(wb_ack), 64'd0);
    checkOutput("mid_rvalid_rst", 64'(ch_rvalid), 64'd0);
    repeat (2) @(negedge cache_clk);
    rst_n = 1'b1;
    wb_req = 1'b0;
    repeat (4) @(negedge cache_clk);
    doAccess(0, 1'b0, 32'h400, 32'hDEADBEEF, 4'h0, 1'b0, w);

    repeat (5) @(negedge cache_clk);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/renas_mem_ctrl.md
Name: renas_mem_ctrl

Overview:
- Parametrised single-clock main-memory controller for renas mcu.
- Replaces the fixed two-interface, dual-clock memory with:
  - NUM_CH request channels arbitrated round-robin;
  - a byte-strobed word array;
  - a WB_DEPTH-entry write-back FIFO with read-after-write hazard protection;
  - a configurable read latency.
- Sits behind the AHB slave wrappers for the I/D caches and the cache write buffer.

Parameters:
- DATA_W, 32, data word width; byte lanes = DATA_W/8.
- ADDR_W, 32, byte address width.
- MEM_WORDS, 16384, number of words in the array.
- BASE_ADDR, 32'h400, byte address mapped to word 0.
- NUM_CH, 2, number of request channels (1..8).
- WB_DEPTH, 4, write-back FIFO entries (power of 2, >=2).
- RD_LAT, 2, cycles from grant to read data (1..4).

Ports:
- cache_clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ch_req  in  NUM_CH  per-channel request, held until granted.
- ch_we  in  NUM_CH  1=write, 0=read.
- ch_addr  in  NUM_CH*ADDR_W  byte addresses, channel i at [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*DATA_W  write data.
- ch_be  in  NUM_CH*DATA_W/8  byte enables for writes.
- ch_gnt  out  NUM_CH  one-hot grant, combinational, same cycle as acceptance.
- ch_rvalid  out  NUM_CH  read data valid pulse.
- ch_rdata  out  NUM_CH*DATA_W  read data.
- ch_err  out  NUM_CH  out-of-range read, pulses with rvalid.
- wb_req  in  1  write-back push request.
- wb_addr  in  ADDR_W  write-back byte address (word-aligned).
- wb_data  in  DATA_W  write-back full word.
- wb_ack  out  1  combinational, = wb_req & ~wb_full.
- wb_full  out  1  FIFO count == WB_DEPTH.
- wb_count  out  $clog2(WB_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values:
  - ch_gnt, ch_rvalid, ch_err, wb_full, wb_count all 0; ch_rdata 0.
  - FIFO pointers and round-robin pointer 0.
  - Read pipeline is flushed.
  - Array contents are not reset.
- Array port:
  - Single port, at most one access per cycle: one channel grant OR one FIFO drain.
- Word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
- Out of range = addr < BASE_ADDR or index >= MEM_WORDS:
  - Read: granted normally; returns rdata=0 with err=1.
  - Write: granted and dropped.
- Arbitration priority each cycle:
  1. FIFO drain if wb_full.
  2. FIFO drain if any requesting read hits a pending FIFO entry by word index. That read is not granted this cycle.
  3. Round-robin among eligible ch_req, starting at rr_ptr; on a grant to i, rr_ptr <= (i+1) mod NUM_CH.
  4. FIFO drain if FIFO non-empty and no channel was granted.
- Channel write:
  - Bytes with ch_be=1 are written at the grant edge.
  - No rvalid is produced.
- Channel read:
  - ch_rvalid[i] pulses exactly RD_LAT cycles after ch_gnt[i].
  - Data reflects every write granted or drained before the grant cycle.
  - Back-to-back grants to the same channel give back-to-back rvalid.
- FIFO:
  - Push when wb_ack; pop on drain (full-word write at head index).
  - Push and pop in the same cycle leave wb_count unchanged; wb_ack cannot assert while full.
  - Drain order is strictly FIFO.
  - Two pending entries to the same index both drain in order; the last pushed wins.
- Hazard check:
  - Compares each requesting read's index against all valid FIFO entries, including an entry pushed in the same cycle.
  - A read can therefore never return stale data relative to an acknowledged write-back.
- Channel write vs FIFO entry to the same index:
  - No ordering enforced; whichever reaches the array later wins.
  - Software/cache coherence guarantees this does not occur.
- Reset mid-operation:
  - In-flight reads are discarded (no rvalid after release).
  - FIFO contents are lost; wb_ack is 0 during reset.

Test Plan:
- Reset, then ch0 read at 0x400 after preload 0xDEADBEEF -> ch_gnt[0] same cycle; ch_rvalid[0]=1, rdata=0xDEADBEEF exactly RD_LAT=2 cycles later.
- ch0 and ch1 both hold read requests for 4 cycles -> grants alternate 0,1,0,1; each rvalid 2 cycles after its grant.
- ch0 write 0x11223344, be=4'b0101, to a word holding 0xAAAAAAAA, then read -> rdata=0xAA22AA44.
- Push wb 0x800/0xCAFEF00D, then same cycle ch1 read 0x800 -> read not granted; FIFO drains next edge; read granted after and returns 0xCAFEF00D.
- 4 pushes with channels continuously busy -> wb_full=1, wb_ack=0 on 5th push; next cycle FIFO drains ahead of channels; wb_count 4->3.
- Read 0x300 and read index MEM_WORDS -> rvalid with err=1, rdata=0; assert rst_n low 1 cycle after a grant -> no rvalid, wb_count=0.
